// File: rtl/latch_write_scheduler.sv
// Round-robin arbiter that sequences writes from four requesters into a shared
// gated D latch bank: SETUP guard, EN_CYCLES of enable, HOLD guard with ACK.
module latch_write_scheduler #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned EN_CYCLES = 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [3:0]           REQ,
   input  logic [4*WIDTH-1:0]   DATA,
   output logic [WIDTH-1:0]     LD,
   output logic                 LE,
   output logic [3:0]           GNT,
   output logic [3:0]           ACK,
   output logic                 BUSY
);

   localparam int unsigned NREQ = 4;
   localparam int unsigned CW   = 4;
   localparam int unsigned PW   = 2;

   typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;

   state_t           state, state_nxt;
   logic [PW-1:0]    ptr, ptr_nxt;
   logic [PW-1:0]    win, win_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] ld_nxt;
   logic             le_nxt;
   logic [3:0]       gnt_nxt;
   logic [3:0]       ack_nxt;
   logic             busy_nxt;
   logic             found;
   logic [PW-1:0]    idx;

   // Next-state and next-output logic; every register gets its next value here
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      win_nxt   = win;
      cnt_nxt   = cnt;
      ld_nxt    = LD;
      le_nxt    = 1'b0;
      gnt_nxt   = GNT;
      ack_nxt   = '0;
      found     = 1'b0;
      idx       = '0;

      case (state)
         IDLE: begin
            gnt_nxt = '0;
            for (int k = 0; k < NREQ; k++) begin
               idx = ptr + PW'(k);
               if (!found && REQ[idx]) begin
                  found   = 1'b1;
                  win_nxt = idx;
               end
            end
            if (found) begin
               state_nxt = SETUP;
               gnt_nxt   = 4'(1) << win_nxt;
               for (int k = 0; k < NREQ; k++) begin
                  if (win_nxt == PW'(k)) ld_nxt = DATA[k*WIDTH +: WIDTH];
               end
            end
         end
         SETUP: begin
            state_nxt = ENABLE;
            le_nxt    = 1'b1;
            cnt_nxt   = CW'(EN_CYCLES - 1);
         end
         ENABLE: begin
            if (cnt == '0) begin
               state_nxt = HOLD;
               ack_nxt   = GNT;
            end else begin
               le_nxt  = 1'b1;
               cnt_nxt = cnt - CW'(1);
            end
         end
         HOLD: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            ptr_nxt   = win + PW'(1);
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   // State and output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         ptr   <= '0;
         win   <= '0;
         cnt   <= '0;
         LD    <= '0;
         LE    <= 1'b0;
         GNT   <= '0;
         ACK   <= '0;
         BUSY  <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         win   <= win_nxt;
         cnt   <= cnt_nxt;
         LD    <= ld_nxt;
         LE    <= le_nxt;
         GNT   <= gnt_nxt;
         ACK   <= ack_nxt;
         BUSY  <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_latch_write_scheduler.sv
// Bench for latch_write_scheduler: vector table of single writes, scoreboard of
// expected grants/acks, and directed contention, mid-write change and reset cases.
module tb_latch_write_scheduler;

   localparam int unsigned WIDTH     = 8;
   localparam int unsigned EN_CYCLES = 2;
   localparam int unsigned NVEC      = 10;

   logic                 CLK = 1'b0;
   logic                 RST;
   logic [3:0]           REQ;
   logic [4*WIDTH-1:0]   DATA;
   logic [WIDTH-1:0]     LD;
   logic                 LE;
   logic [3:0]           GNT;
   logic [3:0]           ACK;
   logic                 BUSY;

   typedef struct {
      logic [3:0]       req;
      logic [31:0]      data;
      logic [3:0]       exp_gnt;
      logic [WIDTH-1:0] exp_ld;
   } vec_t;

   typedef struct {
      logic [3:0]       gnt;
      logic [WIDTH-1:0] ld;
   } exp_t;

   vec_t       vecs [NVEC];
   exp_t       exp_q [$];
   logic [3:0] ack_q [$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int grant_cnt = 0;
   int last_grant = 0;

   latch_write_scheduler #(.WIDTH(WIDTH), .EN_CYCLES(EN_CYCLES)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .DATA(DATA),
      .LD(LD), .LE(LE), .GNT(GNT), .ACK(ACK), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle monitor: invariants plus scoreboard of grants and acks
   logic             prev_le;
   logic [WIDTH-1:0] prev_ld;
   logic [3:0]       prev_gnt;
   int               le_w;
   always @(posedge CLK) begin
      exp_t e;
      #1;
      cyc++;
      if (RST) begin
         prev_le  = 1'b0;
         prev_ld  = '0;
         prev_gnt = '0;
         le_w     = 0;
         ack_q.delete();
      end else begin
         chk("gnt_onehot", 32'($onehot0(GNT)), 32'd1);
         chk("ack_onehot", 32'($onehot0(ACK)), 32'd1);
         chk("ack_without_gnt", 32'(ACK & ~GNT), 32'd0);
         if (LE && prev_le) chk("ld_change_while_le", 32'(LD), 32'(prev_ld));
         if (LE) le_w++;
         else if (le_w != 0) begin
            chk("le_width", 32'(le_w), 32'(EN_CYCLES));
            le_w = 0;
         end
         if (GNT != 0 && prev_gnt == 0) begin
            grant_cnt++;
            last_grant = cyc;
            if (exp_q.size() == 0) chk("unexpected_grant", 32'(GNT), 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("sb_gnt", 32'(GNT), 32'(e.gnt));
               chk("sb_ld", 32'(LD), 32'(e.ld));
               ack_q.push_back(e.gnt);
            end
         end
         if (ACK != 0) begin
            if (ack_q.size() == 0) chk("unexpected_ack", 32'(ACK), 32'd0);
            else chk("sb_ack", 32'(ACK), 32'(ack_q.pop_front()));
         end
         prev_le  = LE;
         prev_ld  = LD;
         prev_gnt = GNT;
      end
   end

   // One full write; the first edge after driving is the one that samples REQ in IDLE
   task automatic run_vec(input vec_t v);
      @(negedge CLK);
      REQ  = v.req;
      DATA = v.data;
      if (v.exp_gnt == 0) begin
         repeat (4) begin
            @(posedge CLK); #1;
            chk("idle_gnt", 32'(GNT), 32'd0);
            chk("idle_busy", 32'(BUSY), 32'd0);
            chk("idle_ld", 32'(LD), 32'(v.exp_ld));
         end
         @(negedge CLK);
         REQ = '0;
         return;
      end
      exp_q.push_back('{gnt: v.exp_gnt, ld: v.exp_ld});
      @(posedge CLK); #1;
      chk("setup_gnt", 32'(GNT), 32'(v.exp_gnt));
      chk("setup_le", 32'(LE), 32'd0);
      chk("setup_busy", 32'(BUSY), 32'd1);
      @(negedge CLK);
      REQ  = '0;
      DATA = ~v.data;
      for (int e = 0; e < int'(EN_CYCLES); e++) begin
         @(posedge CLK); #1;
         chk("enable_le", 32'(LE), 32'd1);
         chk("enable_ld", 32'(LD), 32'(v.exp_ld));
         chk("enable_ack", 32'(ACK), 32'd0);
      end
      @(posedge CLK); #1;
      chk("hold_ack", 32'(ACK), 32'(v.exp_gnt));
      chk("hold_le", 32'(LE), 32'd0);
      chk("hold_ld", 32'(LD), 32'(v.exp_ld));
      @(posedge CLK); #1;
      chk("done_busy", 32'(BUSY), 32'd0);
      chk("done_gnt", 32'(GNT), 32'd0);
      chk("done_ack", 32'(ACK), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int g0;
      int t_prev;
      vec_t v;
      vecs[0] = '{4'b0001, 32'h1F1E1DA5, 4'b0001, 8'hA5};
      vecs[1] = '{4'b0001, 32'h2F2E2D5A, 4'b0001, 8'h5A};
      vecs[2] = '{4'b0011, 32'h3F3E3D3C, 4'b0010, 8'h3D};
      vecs[3] = '{4'b1001, 32'h4F4E4D4C, 4'b1000, 8'h4F};
      vecs[4] = '{4'b1110, 32'h5F5E5D5C, 4'b0010, 8'h5D};
      vecs[5] = '{4'b0100, 32'h6F6E6D6C, 4'b0100, 8'h6E};
      vecs[6] = '{4'b0101, 32'h7F7E7D7C, 4'b0001, 8'h7C};
      vecs[7] = '{4'b0101, 32'h8F8E8D8C, 4'b0100, 8'h8E};
      vecs[8] = '{4'b1000, 32'h9F9E9D9C, 4'b1000, 8'h9F};
      vecs[9] = '{4'b0000, 32'hAFAEADAC, 4'b0000, 8'h9F};

      RST  = 1'b1;
      REQ  = '0;
      DATA = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_ld", 32'(LD), 32'd0);
      chk("rst_le", 32'(LE), 32'd0);
      chk("rst_gnt", 32'(GNT), 32'd0);
      chk("rst_ack", 32'(ACK), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      @(negedge CLK);
      RST = 1'b0;

      for (int i = 0; i < int'(NVEC); i++) run_vec(vecs[i]);

      // Continuous contention: 0,1,2,3,0 spaced EN_CYCLES+3 apart
      @(negedge CLK);
      REQ  = 4'b1111;
      DATA = 32'hD3D2D1D0;
      exp_q.push_back('{gnt: 4'b0001, ld: 8'hD0});
      exp_q.push_back('{gnt: 4'b0010, ld: 8'hD1});
      exp_q.push_back('{gnt: 4'b0100, ld: 8'hD2});
      exp_q.push_back('{gnt: 4'b1000, ld: 8'hD3});
      exp_q.push_back('{gnt: 4'b0001, ld: 8'hD0});
      t_prev = 0;
      for (int i = 0; i < 5; i++) begin
         g0 = grant_cnt;
         for (int w = 0; w < 12 && grant_cnt == g0; w++) @(negedge CLK);
         chk("contention_grant_seen", 32'(grant_cnt - g0), 32'd1);
         if (i > 0) chk("contention_spacing", 32'(last_grant - t_prev), 32'(EN_CYCLES + 3));
         t_prev = last_grant;
      end
      REQ = '0;
      repeat (EN_CYCLES + 4) @(negedge CLK);
      chk("contention_idle", 32'(BUSY), 32'd0);

      // Data and request change mid-write are ignored; ACK still issued
      REQ  = 4'b0001;
      DATA = 32'h000000A5;
      exp_q.push_back('{gnt: 4'b0001, ld: 8'hA5});
      repeat (2) @(posedge CLK);
      #1;
      chk("mid_le", 32'(LE), 32'd1);
      @(negedge CLK);
      DATA = 32'h0000003C;
      REQ  = '0;
      @(posedge CLK); #1;
      chk("mid_ld_kept", 32'(LD), 32'hA5);
      @(posedge CLK); #1;
      chk("mid_ack", 32'(ACK), 32'b0001);
      repeat (6) begin
         @(posedge CLK); #1;
         chk("mid_no_regrant", 32'(GNT), 32'd0);
      end

      // Reset while LE is high aborts the write with no ACK
      @(negedge CLK);
      REQ  = 4'b0010;
      DATA = 32'h00007700;
      exp_q.push_back('{gnt: 4'b0010, ld: 8'h77});
      repeat (2) @(posedge CLK);
      #1;
      chk("abort_le_before", 32'(LE), 32'd1);
      @(negedge CLK);
      RST = 1'b1;
      REQ = '0;
      @(posedge CLK); #1;
      chk("abort_ld", 32'(LD), 32'd0);
      chk("abort_le", 32'(LE), 32'd0);
      chk("abort_gnt", 32'(GNT), 32'd0);
      chk("abort_ack", 32'(ACK), 32'd0);
      chk("abort_busy", 32'(BUSY), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      repeat (5) begin
         @(posedge CLK); #1;
         chk("abort_no_ack", 32'(ACK), 32'd0);
      end
      v = '{4'b1000, 32'hC3000000, 4'b1000, 8'hC3};
      run_vec(v);

      repeat (3) @(posedge CLK);
      #1;
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      chk("ack_q_empty", 32'(ack_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/latch_write_scheduler.md
LATCH_WRITE_SCHEDULER -- requirements
Module: latch_write_scheduler

Interface
REQ-001 Parameter WIDTH, default 8: data width of the shared gated D latch bank.
REQ-002 Parameter EN_CYCLES, default 2: number of clock cycles the latch enable is held high per write; legal range 1..15.
REQ-003 CLK  input  1: single clock; all state changes on its rising edge.
REQ-004 RST  input  1: reset, synchronous and active-high.
REQ-005 REQ  input  4: per-requester write request, level-sensitive; bit i belongs to requester i.
REQ-006 DATA  input  4*WIDTH: requester data; DATA[i*WIDTH +: WIDTH] belongs to requester i.
REQ-007 LD  output  WIDTH: registered data driven to the latch D inputs.
REQ-008 LE  output  1: registered latch enable, driven to the latch E input.
REQ-009 GNT  output  4: registered one-hot grant; all zero when idle.
REQ-010 ACK  output  4: registered one-cycle pulse marking write completion for requester i.
REQ-011 BUSY  output  1: high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, SETUP, ENABLE, HOLD.
REQ-013 IDLE, REQ==0: stay in IDLE with LE=0, GNT=0, ACK=0, and LD unchanged.
REQ-014 IDLE, REQ!=0: select a winner round-robin, searching from index PTR upward modulo 4.
- On the next edge: GNT is set one-hot to the winner, LD captures the winner's DATA slice, and the state goes to SETUP.
REQ-015 SETUP lasts exactly 1 cycle with LE=0 and LD stable, then goes to ENABLE.
REQ-016 ENABLE lasts exactly EN_CYCLES cycles with LE=1 and LD stable.
- A 4-bit counter is loaded on entry and decremented each cycle.
- When the counter expires, the state goes to HOLD.
REQ-017 HOLD lasts exactly 1 cycle with LE=0 and LD stable.
- ACK[winner]=1 for this cycle only.
- PTR is set to (winner+1) mod 4.
- Next state is IDLE, and GNT clears on that edge.
REQ-018 Timing, with REQ sampled high in IDLE at edge 0:
- GNT and LD are valid after edge 1.
- LE is high after edges 2 .. 1+EN_CYCLES.
- ACK is high after edge 2+EN_CYCLES.
- IDLE is reached after edge 3+EN_CYCLES.
REQ-019 Back-to-back writes SHALL be spaced EN_CYCLES+3 cycles apart (grant to grant); no grant is issued while BUSY.
REQ-020 LD SHALL change only on the IDLE->SETUP edge, so it is never modified while LE=1 or during the SETUP/HOLD guard cycles.
REQ-021 Changes to DATA or REQ after capture SHALL be ignored; a REQ withdrawn mid-transaction still completes the transaction and produces ACK.
REQ-022 A REQ still high in the IDLE cycle after ACK SHALL be treated as a new request, subject to the round-robin pointer.
REQ-023 Simultaneous requests: exactly one grant is issued; under continuous contention each requester is serviced once per 4 grants.
REQ-024 At most one GNT bit and at most one ACK bit SHALL be high in any cycle, and ACK[i] only when GNT[i] is high.

Reset
REQ-025 With RST=1 at a rising edge, the registers SHALL take these values, overriding all other behaviour:
- state=IDLE, LE=0, LD=0, GNT=0, ACK=0, BUSY=0, PTR=0, counter=0.
REQ-026 A reset during SETUP, ENABLE or HOLD SHALL abort the write: LE falls at that edge and no ACK is issued.
REQ-027 The first cycle after reset release SHALL behave as IDLE.

Verification (WIDTH=8, EN_CYCLES=2)
REQ-028 Single write: REQ=0001, DATA0=8'hA5 -> GNT=0001 and LD=A5 after edge 1; LE=1 after edges 2-3; ACK=0001 after edge 4; BUSY=0 after edge 5.
REQ-029 Contention: REQ=1111 held, distinct DATA per requester -> grants in order 0,1,2,3,0, each 5 cycles apart, with LD matching the granted requester's slice each time.
REQ-030 Pointer fairness: after requester 2 is serviced, REQ=0101 -> requester 0 is granted (search starts at 3 and wraps); the next grant goes to requester 2.
REQ-031 Data/request change mid-write: DATA0 changes to 8'h3C and REQ0 drops during ENABLE -> LD stays A5, ACK0 is still pulsed, and no new grant follows.
REQ-032 Reset mid-write: RST=1 for one cycle while LE=1 -> all outputs are 0 after that edge, no ACK appears, and the next REQ=1000 is granted to requester 3 with the normal timing.
REQ-033 A bench checker SHALL flag any LD change while LE=1, any multi-hot GNT or ACK, and any LE high pulse whose width differs from EN_CYCLES.
